nms_stream: RTL and testbench

- Non-maximum suppression stage of the Canny pipeline. Sits directly downstream of the Sobel magnitude path and arctan_lut.
- Consumes a raster-order stream of gradient magnitude plus signed angle (degrees, -90..90).
- Quantizes each angle to one of 4 directions and buffers two image lines to form a 3x3 magnitude window.
- Emits the thinned magnitude stream, one output pixel per input pixel, to the hysteresis stage.

---
 rtl/nms_stream.sv | 221 ++++++++++++++++++++++
 tb/tb_nms_stream.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nms_stream.sv
// nms_stream: non-maximum suppression for a raster stream of gradient magnitude
// plus signed angle. Each angle is reduced to a 2-bit direction bin. Two line
// buffers and a 3x3 window feed the keep/suppress decision. The block emits one
// thinned output per input, and injects flush pads after the last input pixel.
// Optional feature macro: NMS_LOW_THRESH_EN adds a thr_low input; a kept pixel
// whose value is below thr_low is forced to zero.

`ifndef NBIT_SOBEL
`define NBIT_SOBEL 8
`endif

module nms_stream #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int NBIT_MAG = 12,
    parameter int NBIT_ANG = `NBIT_SOBEL
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sof,
    input  logic [NBIT_MAG-1:0]        in_mag,
    input  logic signed [NBIT_ANG-1:0] in_ang,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sof,
    output logic                       out_eof,
`ifdef NMS_LOW_THRESH_EN
    input  logic [NBIT_MAG-1:0]        thr_low,
`endif
    output logic [NBIT_MAG-1:0]        out_mag
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_ZERO = CW'(0);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_ZERO = RW'(0);
    localparam logic [NBIT_MAG-1:0] MAG_ZERO = {NBIT_MAG{1'b0}};

    localparam logic signed [NBIT_ANG-1:0] ANG_P22 = NBIT_ANG'(22);
    localparam logic signed [NBIT_ANG-1:0] ANG_N22 = NBIT_ANG'(-22);
    localparam logic signed [NBIT_ANG-1:0] ANG_P23 = NBIT_ANG'(23);
    localparam logic signed [NBIT_ANG-1:0] ANG_N23 = NBIT_ANG'(-23);
    localparam logic signed [NBIT_ANG-1:0] ANG_P67 = NBIT_ANG'(67);
    localparam logic signed [NBIT_ANG-1:0] ANG_N67 = NBIT_ANG'(-67);

    localparam logic [1:0] BIN_D0   = 2'd0;
    localparam logic [1:0] BIN_D45  = 2'd1;
    localparam logic [1:0] BIN_D90  = 2'd2;
    localparam logic [1:0] BIN_D135 = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;

    // Quantise a signed angle in degrees to one of four gradient directions.
    function automatic logic [1:0] ang_bin(input logic signed [NBIT_ANG-1:0] a);
        logic [1:0] b;
        if (a >= ANG_N22 && a <= ANG_P22) begin
            b = BIN_D0;
        end else if (a >= ANG_P23 && a <= ANG_P67) begin
            b = BIN_D45;
        end else if (a >= ANG_N67 && a <= ANG_N23) begin
            b = BIN_D135;
        end else begin
            b = BIN_D90;
        end
        return b;
    endfunction

    state_t            state_r;
    logic [CW-1:0]     col_r, ocol_r;
    logic [RW-1:0]     row_r, orow_r;

    // Centre line carries {bin, mag}; the upper line needs only the magnitude.
    logic [NBIT_MAG+1:0] lb1_r [IMG_W];
    logic [NBIT_MAG-1:0] lb2_r [IMG_W];

    // Two stored window columns; the third (newest) column comes straight from
    // the line-buffer reads and the incoming pixel.
    logic [NBIT_MAG-1:0] a_top_r, a_mid_r, a_bot_r;
    logic [NBIT_MAG-1:0] b_top_r, b_mid_r, b_bot_r;
    logic [1:0]          b_bin_r;

    logic                acc_s, take_s, pad_s, border_s, keep_s, first_s, last_s;
    logic [CW-1:0]       wr_col_s;
    logic [NBIT_MAG+1:0] lb1_rd_s;
    logic [NBIT_MAG-1:0] c_top_s, c_mid_s, n1_s, n2_s, pix_mag_s;

    assign in_ready = !rst && (state_r != FLUSH) && (!out_valid || out_ready);

    // Window neighbours, keep decision, border mask and handshake qualifiers.
    always_comb begin
        acc_s    = in_valid && in_ready;
        take_s   = acc_s && (in_sof || state_r == FILL || state_r == RUN);
        wr_col_s = in_sof ? COL_ZERO : col_r;
        lb1_rd_s = lb1_r[wr_col_s];
        c_top_s  = lb2_r[wr_col_s];
        c_mid_s  = lb1_rd_s[NBIT_MAG-1:0];
        case (b_bin_r)
            BIN_D0:   begin n1_s = a_mid_r; n2_s = c_mid_s; end
            BIN_D45:  begin n1_s = c_top_s; n2_s = a_bot_r; end
            BIN_D90:  begin n1_s = b_top_r; n2_s = b_bot_r; end
            BIN_D135: begin n1_s = a_top_r; n2_s = in_mag;  end
            default:  begin n1_s = b_top_r; n2_s = b_bot_r; end
        endcase
        border_s = (ocol_r == COL_ZERO) || (ocol_r == COL_LAST) ||
                   (orow_r == ROW_ZERO) || (orow_r == ROW_LAST);
        keep_s   = !border_s && (b_mid_r >= n1_s) && (b_mid_r >= n2_s);
`ifdef NMS_LOW_THRESH_EN
        keep_s   = keep_s && (b_mid_r >= thr_low);
`endif
        pix_mag_s = keep_s ? b_mid_r : MAG_ZERO;
        first_s   = (ocol_r == COL_ZERO) && (orow_r == ROW_ZERO);
        last_s    = (ocol_r == COL_LAST) && (orow_r == ROW_LAST);
        pad_s     = (state_r == FLUSH) && (!out_valid || out_ready) && !(out_valid && out_eof);
    end

    // Line buffers and window shift; contents are don't-care until masked rows pass.
    always_ff @(posedge clk) begin
        if (take_s) begin
            lb1_r[wr_col_s] <= {ang_bin(in_ang), in_mag};
            lb2_r[wr_col_s] <= c_mid_s;
            a_top_r <= b_top_r;
            a_mid_r <= b_mid_r;
            a_bot_r <= b_bot_r;
            b_top_r <= c_top_s;
            b_mid_r <= c_mid_s;
            b_bot_r <= in_mag;
            b_bin_r <= lb1_rd_s[NBIT_MAG+1:NBIT_MAG];
        end
    end

    // Frame FSM, position counters and the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            col_r     <= COL_ZERO;
            row_r     <= ROW_ZERO;
            ocol_r    <= COL_ZERO;
            orow_r    <= ROW_ZERO;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_mag   <= MAG_ZERO;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (acc_s && in_sof) begin
                        state_r <= FILL;
                        col_r   <= COL_ONE;
                        row_r   <= ROW_ZERO;
                        ocol_r  <= COL_ZERO;
                        orow_r  <= ROW_ZERO;
                    end
                end
                FILL, RUN: begin
                    if (acc_s && in_sof) begin
                        state_r <= FILL;
                        col_r   <= COL_ONE;
                        row_r   <= ROW_ZERO;
                        ocol_r  <= COL_ZERO;
                        orow_r  <= ROW_ZERO;
                    end else if (acc_s) begin
                        if (col_r == COL_LAST) begin
                            col_r <= COL_ZERO;
                            row_r <= (row_r == ROW_LAST) ? ROW_ZERO : row_r + ROW_ONE;
                        end else begin
                            col_r <= col_r + COL_ONE;
                        end
                        if (state_r == FILL && row_r == ROW_ONE && col_r == COL_ZERO) begin
                            state_r <= RUN;
                        end
                        if (state_r == RUN) begin
                            out_valid <= 1'b1;
                            out_mag   <= pix_mag_s;
                            out_sof   <= first_s;
                            out_eof   <= last_s;
                            if (ocol_r == COL_LAST) begin
                                ocol_r <= COL_ZERO;
                                orow_r <= (orow_r == ROW_LAST) ? ROW_ZERO : orow_r + ROW_ONE;
                            end else begin
                                ocol_r <= ocol_r + COL_ONE;
                            end
                            if (row_r == ROW_LAST && col_r == COL_LAST) begin
                                state_r <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    // Pads fall entirely on the bottom row / right column, so they emit zero.
                    if (pad_s) begin
                        out_valid <= 1'b1;
                        out_mag   <= MAG_ZERO;
                        out_sof   <= first_s;
                        out_eof   <= last_s;
                        if (ocol_r == COL_LAST) begin
                            ocol_r <= COL_ZERO;
                            orow_r <= (orow_r == ROW_LAST) ? ROW_ZERO : orow_r + ROW_ONE;
                        end else begin
                            ocol_r <= ocol_r + COL_ONE;
                        end
                    end else if (out_valid && out_ready && out_eof) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nms_stream.sv
// Directed bench for nms_stream with an 8x6 frame.
module tb_nms_stream;

    localparam int W = 8;
    localparam int H = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, in_sof;
    logic [11:0]       in_mag;
    logic signed [7:0] in_ang;
    logic              out_valid, out_ready, out_sof, out_eof;
    logic [11:0]       out_mag;
`ifdef NMS_LOW_THRESH_EN
    logic [11:0]       thr_low;
`endif

    int tests = 0;
    int fails = 0;
    int kind  = 0;
    int pang  = 0;

    bit          q_sof[$];
    int          q_mag[$];
    int          q_ang[$];
    logic [13:0] e_q[$];

    nms_stream #(.IMG_W(W), .IMG_H(H), .NBIT_MAG(12), .NBIT_ANG(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_mag(in_mag), .in_ang(in_ang),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof),
`ifdef NMS_LOW_THRESH_EN
        .thr_low(thr_low),
`endif
        .out_mag(out_mag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Test images. kind 0 plateau, 1..3 and 5 vertical ridge on col 3, 4 single peak at (2,3).
    function automatic int img_mag(int r, int c);
        if (kind == 0) return 10;
        if (kind == 4) return (r == 2 && c == 3) ? 50 : 20;
        return (c == 3) ? 50 : 20;
    endfunction

    function automatic int img_ang(int r, int c);
        if (kind == 2) return 90;
        if (kind == 3) return 45;
        if (kind == 4) return pang;
        return 0;
    endfunction

    // 0:D0 (W/E), 1:D45 (NE/SW), 2:D90 (N/S), 3:D135 (NW/SE)
    function automatic int exp_bin(int a);
        if (a >= -22 && a <= 22) return 0;
        if (a >= 23 && a <= 67) return 1;
        if (a >= -67 && a <= -23) return 3;
        return 2;
    endfunction

    // Hand-derived expected output for each test image.
    function automatic int exp_mag(int r, int c);
        int b;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        case (kind)
            0: return 10;
            1, 3: return (c == 3) ? 50 : ((c == 2 || c == 4) ? 0 : 20);
            2: return (c == 3) ? 50 : 20;
            4: begin
                if (r == 2 && c == 3) return 50;
                b = exp_bin(pang);
                if (b == 0 && r == 2 && (c == 2 || c == 4)) return 0;
                if (b == 1 && ((r == 3 && c == 2) || (r == 1 && c == 4))) return 0;
                if (b == 2 && c == 3 && (r == 1 || r == 3)) return 0;
                if (b == 3 && ((r == 1 && c == 2) || (r == 3 && c == 4))) return 0;
                return 20;
            end
            5: return (c == 3) ? 50 : 0;
            default: return 0;
        endcase
    endfunction

    // Queue npix input pixels of the current image and the outputs they must produce.
    task automatic add_frame(input int npix);
        int nout;
        for (int k = 0; k < npix; k++) begin
            q_sof.push_back(k == 0);
            q_mag.push_back(img_mag(k / W, k % W));
            q_ang.push_back(img_ang(k / W, k % W));
        end
        nout = (npix == W * H) ? W * H : ((npix > W + 1) ? npix - W - 1 : 0);
        for (int o = 0; o < nout; o++) begin
            e_q.push_back({(o == 0), (o == W * H - 1), 12'(exp_mag(o / W, o % W))});
        end
    endtask

    task automatic run_seq(input bit stall);
        int ip = 0;
        int op = 0;
        int cyc = 0;
        bit holding = 1'b0;
        logic [13:0] held = 14'd0;
        while (op < e_q.size() && cyc < 4000) begin
            @(negedge clk);
            if (holding) chk($sformatf("stall_hold%0d", op), {18'd0, out_sof, out_eof, out_mag}, {18'd0, held});
            out_ready = stall ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (ip < q_mag.size()) begin
                in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                in_sof   = q_sof[ip];
                in_mag   = 12'(q_mag[ip]);
                in_ang   = 8'(q_ang[ip]);
            end else begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
            end
            #1;
            if (in_valid && in_ready) ip++;
            holding = out_valid && !out_ready;
            held    = {out_sof, out_eof, out_mag};
            if (out_valid && out_ready) begin
                chk($sformatf("pix%0d", op), {18'd0, out_sof, out_eof, out_mag}, {18'd0, e_q[op]});
                op++;
            end
            cyc++;
        end
        if (op < e_q.size()) chk("timeout_outputs", 32'(op), 32'(e_q.size()));
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_extra_output", {31'd0, out_valid}, 32'd0);
        end
        q_sof.delete();
        q_mag.delete();
        q_ang.delete();
        e_q.delete();
    endtask

    initial begin
        int angs[13] = '{0, 22, 23, 45, 67, 68, 90, -90, -68, -67, -45, -23, -22};
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_mag = 12'd0; in_ang = 8'sd0; out_ready = 1'b0;
`ifdef NMS_LOW_THRESH_EN
        thr_low = 12'd0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_state", {27'd0, in_ready, out_valid, out_sof, out_eof, 1'b0}, 32'd0);
        chk("reset_mag", {20'd0, out_mag}, 32'd0);
        rst = 1'b0;

        // Plateau frame preceded by a stray non-sof pixel that must be discarded.
        kind = 0;
        q_sof.push_back(1'b0); q_mag.push_back(99); q_ang.push_back(0);
        add_frame(W * H);
        run_seq(1'b0);

        // Ridge at three angles.
        kind = 1; add_frame(W * H); run_seq(1'b0);
        kind = 2; add_frame(W * H); run_seq(1'b0);
        kind = 3; add_frame(W * H); run_seq(1'b0);

        // Single peak across all bin boundaries.
        kind = 4;
        for (int i = 0; i < 13; i++) begin
            pang = angs[i];
            add_frame(W * H);
            run_seq(1'b0);
        end

        // Random stalls on both sides.
        kind = 0; add_frame(W * H); run_seq(1'b1);
        kind = 1; add_frame(W * H); run_seq(1'b1);

        // Restart with in_sof at pixel 20.
        kind = 0; add_frame(20); add_frame(W * H); run_seq(1'b0);
        kind = 1; add_frame(20); add_frame(W * H); run_seq(1'b1);

        // Reset in mid-frame, then a clean frame.
        kind = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_sof = (k == 0); in_mag = 12'd10; in_ang = 8'sd0;
        end
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("midreset_state", {27'd0, in_ready, out_valid, out_sof, out_eof, 1'b0}, 32'd0);
        chk("midreset_mag", {20'd0, out_mag}, 32'd0);
        rst = 1'b0;
        add_frame(W * H);
        run_seq(1'b0);

`ifdef NMS_LOW_THRESH_EN
        kind = 5; thr_low = 12'd25; add_frame(W * H); run_seq(1'b0);
        thr_low = 12'd0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
